// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: parametrised parallel-in/serial-out UART transmitter.
// Frame = start bit, DATA_WIDTH data bits (LSB first), optional parity bit,
// STOP_BITS stop bits, each bit held for CLKS_PER_BIT clock cycles.
// Optional feature macro: UART_TX_PARITY_EN inserts a parity bit after the data
// bits (even parity when PARITY_ODD=0, odd parity when PARITY_ODD=1).
module uart_tx_serializer #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  ready,
  output logic                  tx,
  output logic                  busy,
  output logic                  done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = $clog2(DATA_WIDTH);

  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd3;
`endif
  localparam logic [2:0] STOP   = 3'd4;

  // Reject parameter combinations the framing logic cannot represent.
  if (DATA_WIDTH < 5 || DATA_WIDTH > 16 || CLKS_PER_BIT < 1 ||
      (STOP_BITS != 1 && STOP_BITS != 2) ||
      (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_badParams
    $error("uart_tx_serializer: illegal parameter value");
  end

  logic [2:0]            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [BW-1:0]         bitIdx_q, bitIdx_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  tx_q, tx_d;
  logic                  done_q, done_d;
  logic                  baudEnd;
`ifdef UART_TX_PARITY_EN
  logic                  parity_q, parity_d;
`endif

  assign baudEnd = (cnt_q == CNT_LAST);

  // Next-state logic: tx_d is the line level for the cycle after this edge.
  always_comb begin
    state_d  = state_q;
    bitIdx_d = bitIdx_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    done_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    cnt_d    = (state_q == IDLE || baudEnd) ? '0 : cnt_q + 1'b1;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (load) begin
          shift_d  = din;
          state_d  = START;
          tx_d     = 1'b0;
          bitIdx_d = '0;
`ifdef UART_TX_PARITY_EN
          parity_d = (^din) ^ (PARITY_ODD != 0);
`endif
        end
      end
      START: begin
        if (baudEnd) begin
          state_d = DATA;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (baudEnd) begin
          shift_d = shift_q >> 1;
          if (bitIdx_q == DATA_LAST) begin
            bitIdx_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d  = PARITY;
            tx_d     = parity_q;
`else
            state_d  = STOP;
            tx_d     = 1'b1;
`endif
          end else begin
            bitIdx_d = bitIdx_q + 1'b1;
            tx_d     = shift_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baudEnd) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      STOP: begin
        tx_d = 1'b1;
        if (baudEnd) begin
          if (bitIdx_q == STOP_LAST) begin
            state_d  = IDLE;
            bitIdx_d = '0;
            done_d   = 1'b1;
          end else begin
            bitIdx_d = bitIdx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // State registers; reset aborts any frame in flight without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bitIdx_q <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bitIdx_q <= bitIdx_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      done_q   <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign tx    = tx_q;
  assign done  = done_q;
  assign busy  = (state_q != IDLE);
  assign ready = (state_q == IDLE);

endmodule
